// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC core: controller states, opcode/mm encodings
// and status-register bit positions ({C, V, N, Z}).
package sisc_pkg;

    typedef enum logic [2:0] {
        S_RST       = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU = 4'h8;
    localparam logic [3:0] OP_BRA = 4'h4;
    localparam logic [3:0] OP_BRR = 4'h5;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] MM_REG = 4'h0;
    localparam logic [3:0] MM_IMM = 4'h8;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_V = 2;
    localparam int ST_C = 3;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition evaluation: an all-zero mask is unconditional, otherwise the
// branch is taken when any status flag selected by the mask is set.
module sisc_br_cond #(
    parameter int STAT_W = 4
) (
    input  logic [STAT_W-1:0] mm,
    input  logic [STAT_W-1:0] stat,
    output logic              taken
);

    assign taken = (mm == '0) || ((mm & stat) != '0);

endmodule

// File: rtl/sisc_ctrl.sv
// Multicycle FETCH/DECODE/EXECUTE/WRITEBACK controller for the SISC core.
// Outputs are Moore-style, derived from the current state and the IR fields.
module sisc_ctrl
    import sisc_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int STAT_W = 4
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic [OP_W-1:0]   opcode,
    input  logic [OP_W-1:0]   mm,
    input  logic [STAT_W-1:0] stat,
    output logic              ir_load,
    output logic              pc_write,
    output logic              pc_sel,
    output logic              br_rel,
    output logic              alu_src,
    output logic              rd_sel,
    output logic              rf_we,
    output logic              stat_en,
    output logic              halted
);

    state_t state;
    state_t state_nxt;

    logic   is_alu;
    logic   is_imm;
    logic   is_br;
    logic   taken;

    // ALU with an unrecognised mm value falls through as a NOP
    assign is_imm = (mm == MM_IMM);
    assign is_alu = (opcode == OP_ALU) && ((mm == MM_REG) || is_imm);
    assign is_br  = (opcode == OP_BRA) || (opcode == OP_BRR);

    sisc_br_cond #(
        .STAT_W (STAT_W)
    ) u_br_cond (
        .mm    (mm),
        .stat  (stat),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst_f) begin
            state <= S_RST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_sel    = 1'b0;
        br_rel    = 1'b0;
        alu_src   = 1'b0;
        rd_sel    = 1'b0;
        rf_we     = 1'b0;
        stat_en   = 1'b0;
        halted    = 1'b0;

        case (state)
            S_RST: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                ir_load   = 1'b1;
                pc_write  = 1'b1;
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                state_nxt = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                state_nxt = S_FETCH;
                if (is_alu) begin
                    alu_src   = is_imm;
                    rd_sel    = is_imm;
                    stat_en   = 1'b1;
                    state_nxt = S_WRITEBACK;
                end else if (is_br && taken) begin
                    // relative target is formed from the PC already bumped in FETCH
                    pc_write = 1'b1;
                    pc_sel   = 1'b1;
                    br_rel   = (opcode == OP_BRR);
                end
            end
            S_WRITEBACK: begin
                rf_we     = 1'b1;
                alu_src   = is_imm;
                rd_sel    = is_imm;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_nxt = S_RST;
            end
        endcase
    end

endmodule

// File: doc/sisc_ctrl.md
Name: sisc_ctrl

Overview:
- Multicycle control unit for the SISC core.
- Consumes the instruction word held in the IR, using fields opcode = ir[31:28] and mm = ir[27:24], plus the 4-bit status register.
- Sequences FETCH/DECODE/EXECUTE/WRITEBACK and drives every load/write enable and mux select in the datapath.
- Sits between the IR/status register and the PC, register file, ALU and status logic. Branch decisions are taken here.

Parameters:
- OP_W, 4, opcode and mm field width
- STAT_W, 4, status width; bit order {C, V, N, Z}

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_f  in  1  synchronous reset, active-high: rst_f=1 sampled at a rising edge resets the block
- opcode  in  4  ir[31:28]
- mm  in  4  ir[27:24]; immediate flag for ALU ops, condition mask for branches
- stat  in  4  current status register {C, V, N, Z}
- ir_load  out  1  IR captures instruction-memory output
- pc_write  out  1  PC register update
- pc_sel  out  1  0 = PC+1, 1 = branch target
- br_rel  out  1  0 = absolute target ir[15:0]; 1 = PC + sign-extended ir[15:0]
- alu_src  out  1  0 = register operand rt; 1 = zero-extended ir[15:0]
- rd_sel  out  1  0 = destination ir[15:12]; 1 = destination ir[19:16]
- rf_we  out  1  register-file write enable
- stat_en  out  1  status register load
- halted  out  1  core stopped

Behaviour:
- States: RST, FETCH, DECODE, EXECUTE, WRITEBACK, HALT. State register is a binary-encoded enum.
- Reset:
  - rst_f=1 at an edge forces RST from any state, including mid-instruction and HALT.
  - In RST all outputs are 0.
  - First edge with rst_f=0 moves RST to FETCH.
- Outputs are Moore-style: a combinational function of state and opcode/mm. No output asserts in a state other than the one listed below.
- Opcode decode:
  - 0x0: NOP
  - 0x8: ALU; mm=0x0 register form, mm=0x8 immediate form
  - 0x4: BRA (absolute)
  - 0x5: BRR (relative)
  - 0xF: HALT
  - All other opcodes, and ALU with any other mm value, behave as NOP.
- FETCH: ir_load=1, pc_write=1, pc_sel=0. Always followed by DECODE.
- DECODE:
  - All enables 0.
  - opcode 0xF -> HALT; otherwise -> EXECUTE.
- EXECUTE:
  - ALU:
    - alu_src = (mm==0x8); rd_sel = (mm==0x8).
    - stat_en=1 for exactly one cycle.
    - Next state WRITEBACK.
  - BRA/BRR:
    - Branch taken when mm==0x0, or when (mm & stat) != 0.
    - If taken: pc_write=1, pc_sel=1, br_rel=(opcode==0x5).
    - Next state FETCH.
    - Relative target is computed from the already-incremented PC.
  - NOP: next state FETCH.
- WRITEBACK:
  - rf_we=1. alu_src and rd_sel hold their EXECUTE values so the ALU result is stable during the write.
  - Next state FETCH.
- Latency:
  - ALU: 4 cycles.
  - NOP/branch: 3 cycles.
  - HALT: 2 cycles to reach HALT state.
- HALT: halted=1, all other enables 0, state holds until rst_f=1.
- stat is sampled only in EXECUTE. A status update from the same instruction (stat_en) is never visible to that instruction's branch decision.
- opcode/mm are stable from DECODE through WRITEBACK because ir_load asserts only in FETCH. The controller does not latch them.

Decomposition:
- Shared package sisc_pkg holds:
  - state enum
  - opcode constants OP_NOP, OP_ALU, OP_BRA, OP_BRR, OP_HLT
  - MM_IMM = 4'h8
  - status bit indices ST_C, ST_V, ST_N, ST_Z
- One sub-module is natural: sisc_br_cond. It is purely combinational: inputs mm and stat, output taken. It is reused later by a pipelined core.
- Next-state and output logic stay in sisc_ctrl.

Test Plan:
1. Reset held for 2 edges, then released, then opcode=0x0 -> all outputs 0 during reset; FETCH on the first edge after release with ir_load=1 and pc_write=1; states repeat FETCH, DECODE, EXECUTE every 3 cycles.
2. opcode=0x8, mm=0x8 (ADDI) -> EXECUTE: alu_src=1, rd_sel=1, stat_en=1; WRITEBACK: rf_we=1 with alu_src=1 and rd_sel=1; next FETCH on cycle 5.
3. opcode=0x8, mm=0x0 (ADD) -> EXECUTE: alu_src=0, rd_sel=0, stat_en=1; WRITEBACK: rf_we=1; stat_en is never high in WRITEBACK.
4. opcode=0x5, mm=0x1 with stat=0x1 -> EXECUTE: pc_write=1, pc_sel=1, br_rel=1. Repeat with stat=0xE -> pc_write=0 in EXECUTE. Repeat with mm=0x0, opcode=0x4 -> taken, br_rel=0.
5. opcode=0xF -> HALT entered after DECODE; halted=1 for 10+ cycles with all enables 0; rst_f=1 for one edge -> halted=0, state RST.
6. rst_f=1 asserted in WRITEBACK of an ALU op -> rf_we=0 on the following cycle; no second rf_we pulse after release. Also opcode=0x3 -> NOP timing, no enables in EXECUTE.
